// File: rtl/axis_upsizer.sv
// Packs RATIO narrow AXI-Stream beats into one wide beat; tlast flushes a partial
// word with per-lane tkeep so packet boundaries survive the width change.
module axis_upsizer #(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int RATIO          = 2
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [AXI_DATA_WIDTH-1:0]       s_axis_tdata,
  input  logic                            s_axis_tvalid,
  input  logic                            s_axis_tlast,
  output logic                            s_axis_tready,
  output logic [AXI_DATA_WIDTH*RATIO-1:0] m_axis_tdata,
  output logic [RATIO-1:0]                m_axis_tkeep,
  output logic                            m_axis_tvalid,
  output logic                            m_axis_tlast,
  input  logic                            m_axis_tready
);
  localparam int W  = AXI_DATA_WIDTH;
  localparam int CW = $clog2(RATIO);

  logic [CW-1:0]             r_cnt;
  logic [RATIO-1:0][W-1:0]   r_acc;
  logic [RATIO-1:0]          r_keep;
  logic [RATIO-1:0][W-1:0]   r_out_data;
  logic [RATIO-1:0]          r_out_keep;
  logic                      r_out_vld;
  logic                      r_out_last;

  logic                      w_s_ready;
  logic                      w_accept;
  logic                      w_done;
  logic [RATIO-1:0]          w_lane_bit;
  logic [RATIO-1:0][W-1:0]   w_merged;

  // Ready depends only on output-register state and downstream ready.
  assign w_s_ready  = !r_out_vld || m_axis_tready;
  assign w_accept   = s_axis_tvalid && w_s_ready;
  assign w_done     = w_accept && ((r_cnt == CW'(RATIO-1)) || s_axis_tlast);
  assign w_lane_bit = RATIO'(1) << r_cnt;

  always_comb begin
    w_merged        = r_acc;
    w_merged[r_cnt] = s_axis_tdata;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_cnt      <= '0;
      r_acc      <= '0;
      r_keep     <= '0;
      r_out_data <= '0;
      r_out_keep <= '0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
    end else if (w_done) begin
      // Accumulator clears so lanes beyond a tlast flush read as zero next word.
      r_out_data <= w_merged;
      r_out_keep <= r_keep | w_lane_bit;
      r_out_last <= s_axis_tlast;
      r_out_vld  <= 1'b1;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_keep     <= '0;
    end else begin
      if (r_out_vld && m_axis_tready) r_out_vld <= 1'b0;
      if (w_accept) begin
        r_acc  <= w_merged;
        r_keep <= r_keep | w_lane_bit;
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign s_axis_tready = w_s_ready;
  assign m_axis_tdata  = r_out_data;
  assign m_axis_tkeep  = r_out_keep;
  assign m_axis_tvalid = r_out_vld;
  assign m_axis_tlast  = r_out_last;
endmodule
